// File: rtl/cache_controller.sv
// cache_controller: 2-way set-associative, write-through, no-write-allocate data cache.
// Read hits finish in the same cycle; misses and all writes go through the SRAM handshake.
module cache_controller #(
  parameter int ADDRESS_LEN = 32,
  parameter int DATA_LEN    = 32,
  parameter int INDEX_LEN   = 6,
  parameter int TAG_LEN     = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDRESS_LEN-1:0] address,
  input  logic [DATA_LEN-1:0]    write_data,
  input  logic                   read_en,
  input  logic                   write_en,
  output logic [DATA_LEN-1:0]    read_data,
  output logic                   ready,
  output logic [ADDRESS_LEN-1:0] sram_address,
  output logic [DATA_LEN-1:0]    sram_write_data,
  output logic                   sram_read_en,
  output logic                   sram_write_en,
  input  logic [DATA_LEN-1:0]    sram_read_data,
  input  logic                   sram_ready
);
  localparam int SETS = 1 << INDEX_LEN;
  typedef enum logic [1:0] {IDLE, SRAM_READ, SRAM_WRITE} state_t;
  state_t state, state_n;
  logic busy_seen;
  logic [SETS-1:0] valid0, valid1, lru;
  logic [TAG_LEN-1:0] tag0 [SETS];
  logic [TAG_LEN-1:0] tag1 [SETS];
  logic [DATA_LEN-1:0] data0 [SETS];
  logic [DATA_LEN-1:0] data1 [SETS];
  logic [INDEX_LEN-1:0] idx;
  logic [TAG_LEN-1:0] tag;
  logic hit0, hit1, hit, hit_way, victim, done, rd_hit, fill, wr_upd;
  logic unused_addr;
  assign idx = address[INDEX_LEN+1:2];
  assign tag = address[INDEX_LEN+TAG_LEN+1:INDEX_LEN+2];
  assign unused_addr = ^{address[ADDRESS_LEN-1:INDEX_LEN+TAG_LEN+2], address[1:0]};
  assign hit0 = valid0[idx] && tag0[idx] == tag;
  assign hit1 = valid1[idx] && tag1[idx] == tag;
  assign hit = hit0 || hit1;
  assign hit_way = !hit0;
  assign victim = !valid0[idx] ? 1'b0 : !valid1[idx] ? 1'b1 : lru[idx];
  // completion needs the controller to have gone busy first, so a stale sram_ready=1 is ignored
  assign done = sram_ready && busy_seen;
  assign rd_hit = state == IDLE && read_en && hit;
  assign fill = state == SRAM_READ && done;
  assign wr_upd = state == SRAM_WRITE && done && hit;
  assign sram_address = address;
  assign sram_write_data = write_data;
  assign sram_read_en = state == SRAM_READ;
  assign sram_write_en = state == SRAM_WRITE;
  always_comb begin
    state_n = state;
    ready = 1'b0;
    read_data = '0;
    case (state)
      IDLE: begin
        ready = read_en ? hit : !write_en;
        read_data = rd_hit ? (hit0 ? data0[idx] : data1[idx]) : '0;
        state_n = read_en ? (hit ? IDLE : SRAM_READ) : write_en ? SRAM_WRITE : IDLE;
      end
      SRAM_READ: begin
        ready = done;
        read_data = done ? sram_read_data : '0;
        state_n = done ? IDLE : SRAM_READ;
      end
      default: begin
        ready = done;
        state_n = done ? IDLE : SRAM_WRITE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy_seen <= 1'b0;
      valid0 <= '0;
      valid1 <= '0;
      lru <= '0;
    end else begin
      state <= state_n;
      busy_seen <= state != IDLE && !done && (busy_seen || !sram_ready);
      if (rd_hit || wr_upd) lru[idx] <= ~hit_way;
      if (fill) begin
        lru[idx] <= ~victim;
        if (victim) valid1[idx] <= 1'b1;
        else valid0[idx] <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && fill) begin
      if (victim) begin
        tag1[idx] <= tag;
        data1[idx] <= sram_read_data;
      end else begin
        tag0[idx] <= tag;
        data0[idx] <= sram_read_data;
      end
    end
    if (!rst && wr_upd) begin
      if (hit_way) data1[idx] <= write_data;
      else data0[idx] <= write_data;
    end
  end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- 2-way set-associative, write-through, no-write-allocate data cache between the MEM stage (pipeline side) and the SRAM controller (memory side).
- Acts as initiator toward the SRAM controller's read_en/write_en/ready handshake.
- Read hits complete in the same cycle. Read misses fill one word from SRAM. Every write goes to SRAM.
- Stalls the pipeline through `ready` whenever SRAM is involved.

Parameters:
- ADDRESS_LEN, 32, pipeline/SRAM byte-address width.
- DATA_LEN, 32, word width.
- INDEX_LEN, 6, set index bits (64 sets); index = address[INDEX_LEN+1:2].
- TAG_LEN, 11, tag bits; tag = address[INDEX_LEN+TAG_LEN+1:INDEX_LEN+2] = address[18:8]. Higher address bits are ignored (alias).

Ports:
- clk, input, 1: system clock, all state on rising edge.
- rst, input, 1: synchronous active-high reset.
- address, input, ADDRESS_LEN: pipeline byte address (word aligned).
- write_data, input, DATA_LEN: pipeline store data.
- read_en, input, 1: pipeline load request.
- write_en, input, 1: pipeline store request.
- read_data, output, DATA_LEN: load result, valid when ready=1 and a read is in progress.
- ready, output, 1: 1 = request done / no stall; 0 = pipeline must freeze and hold its inputs.
- sram_address, output, ADDRESS_LEN: address to the SRAM controller, equal to `address`.
- sram_write_data, output, DATA_LEN: data to the SRAM controller, equal to `write_data`.
- sram_read_en, output, 1: read request to the SRAM controller.
- sram_write_en, output, 1: write request to the SRAM controller.
- sram_read_data, input, DATA_LEN: word returned by the SRAM controller.
- sram_ready, input, 1: SRAM controller idle/done.

Behaviour:
- Reset is synchronous. Clock and reset are fixed as: one clock (clk); rst is synchronous and active-high.
- On reset:
  - All valid bits cleared and all LRU bits set to 0.
  - FSM goes to IDLE.
  - sram_read_en=0, sram_write_en=0.
  - ready=1 while no request is present; read_data=0.
- Storage: per set, two ways of {valid, tag[TAG_LEN], data[DATA_LEN]} plus one LRU bit. The LRU bit names the way to replace next.
- Hit: valid && tag match in either way. Both ways matching cannot occur; if it does, way 0 wins.
- Request priority: read_en has priority. When read_en=1 and write_en=1 together, the request is treated as a read only.
- FSM states: IDLE, SRAM_READ, SRAM_WRITE.
- IDLE:
  - read_en and hit: read_data = hit word (combinational); ready=1; LRU[set] <= ~hit_way at the edge; stay in IDLE; no SRAM access.
  - read_en and miss: ready=0; next state SRAM_READ.
  - write_en (hit or miss): ready=0; next state SRAM_WRITE.
  - No request: ready=1; read_data=0.
- SRAM_READ / SRAM_WRITE:
  - Drive sram_read_en=1 (or sram_write_en=1) from state entry until completion.
  - A busy_seen flag is set on any cycle with sram_ready=0.
  - Completion cycle = first cycle with sram_ready=1 && busy_seen.
  - Before completion: ready=0. The pipeline must keep address, write_data and the enables stable.
- SRAM_READ completion cycle:
  - read_data = sram_read_data combinationally, ready=1.
  - At that edge the line is filled: victim = an invalid way (way 0 if both are invalid), else way LRU[set]. Set valid=1, tag, data; LRU[set] <= ~victim.
  - Return to IDLE; sram_read_en=0 from the next cycle.
- SRAM_WRITE completion cycle:
  - ready=1.
  - If the address hits at that edge, the hit way's data <= write_data and LRU[set] <= ~hit_way.
  - If it misses, the cache is unchanged (no allocate).
  - Return to IDLE.
- The cache never drops sram_*_en before completion. It never re-issues: the enable is low for at least one cycle before the next access.
- Reset mid-access: at the rst edge the FSM returns to IDLE, the enables drop the next cycle, no fill occurs, and all lines become invalid.
- Latency:
  - Hit = 0 extra cycles.
  - Miss or write = SRAM controller access time + 1 entry cycle. With the current SRAM controller this is ready low for 6 cycles, high in the 7th.

Test Plan:
- Reset, then read 0x400 (SRAM model returns 0xDEADBEEF) -> sram_read_en=1 and sram_address=0x400 until completion; ready=0 until sram_ready returns; read_data=0xDEADBEEF with ready=1; immediate reread of 0x400 hits with ready=1 the same cycle and sram_read_en stays 0.
- After the fill above, write 0x400 with 0x12345678 -> sram_write_en=1 and sram_write_data=0x12345678, ready=0 until completion; reread 0x400 hits with 0x12345678 and no SRAM read.
- Write 0x800 with 0xCAFEF00D on a cold cache -> SRAM write occurs; following read of 0x800 misses (sram_read_en=1).
- LRU, all addresses in set 0: read 0x400, read 0x500, read 0x400, read 0x600 -> 0x600 evicts 0x500; read 0x400 hits; read 0x500 misses.
- rst=1 during SRAM_READ of 0x400 -> next cycle sram_read_en=0 and ready=1 (no request); subsequent read of 0x400 misses again.
- read_en=1 and write_en=1 at 0x700 -> only sram_read_en asserts; sram_write_en stays 0 throughout.
